// File: rtl/lcd_16207_timed_bridge.sv
// Avalon-MM slave to HD44780/16207 character-LCD bridge with counter-timed RS/RW setup, E pulse, hold and recovery.
// Define LCD_BUSY_POLL_EN to poll the busy flag (DB7) before every access except a master status read.
module lcd_16207_timed_bridge #(
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned E_HIGH_CYCLES  = 23,
   parameter int unsigned HOLD_CYCLES    = 1,
   parameter int unsigned RECOVER_CYCLES = 24,
   parameter int unsigned POLL_LIMIT     = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] address,
   input  logic       read,
   input  logic       write,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       waitrequest,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   inout  logic [7:0] LCD_data
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 || E_HIGH_CYCLES < 1 || E_HIGH_CYCLES > 255 ||
       HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || RECOVER_CYCLES < 1 || RECOVER_CYCLES > 255 ||
       POLL_LIMIT < 1 || POLL_LIMIT > 255) begin : g_param_range
      $error("lcd_16207_timed_bridge: cycle parameters must be in 1..255");
   end

   localparam logic [7:0] SETUP_LOAD   = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] E_HIGH_LOAD  = 8'(E_HIGH_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] RECOVER_LOAD = 8'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_E_HIGH, ST_HOLD, ST_RECOVER} state_t;

   state_t     state, next_state;
   logic [7:0] cnt, next_cnt, lat_data;
   logic       lat_rs, lat_rw, lat_write, ack, drive;
   logic       done, load, sample, active, in_poll, rs_src, rw_src, capture;
   logic       next_ack, next_e, next_rs, next_rw, next_drive;
`ifdef LCD_BUSY_POLL_EN
   localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);
   logic       polling, next_polling, busy;
   logic [7:0] poll_cnt;
`endif

   always_comb begin
      done       = (cnt == '0);
      next_state = state;
      next_cnt   = cnt - 8'd1;
      load       = 1'b0;
      sample     = 1'b0;
      case (state)
         ST_IDLE: begin
            next_cnt = '0;
            if (read || write) begin
               load       = 1'b1;
               next_state = ST_SETUP;
               next_cnt   = SETUP_LOAD;
            end
         end
         ST_SETUP: if (done) begin
            next_state = ST_E_HIGH;
            next_cnt   = E_HIGH_LOAD;
         end
         ST_E_HIGH: if (done) begin
            sample     = 1'b1;
            next_state = ST_HOLD;
            next_cnt   = HOLD_LOAD;
         end
         ST_HOLD: if (done) begin
            next_state = ST_RECOVER;
            next_cnt   = RECOVER_LOAD;
         end
         ST_RECOVER: if (done) begin
            next_state = ST_IDLE;
            next_cnt   = '0;
`ifdef LCD_BUSY_POLL_EN
            if (polling) begin
               next_state = ST_SETUP;
               next_cnt   = SETUP_LOAD;
            end
`endif
         end
         default: begin
            next_state = ST_IDLE;
            next_cnt   = '0;
         end
      endcase

`ifdef LCD_BUSY_POLL_EN
      // Polling decision is made at each RECOVER exit; the last poll chains straight into the real access.
      next_polling = polling;
      if (load)
         next_polling = write || (address != 2'b01);
      else if (state == ST_RECOVER && done && polling)
         next_polling = busy && (poll_cnt < POLL_MAX);
      in_poll = next_polling;
      capture = sample && lat_rw && !lat_write && !polling;
`else
      in_poll = 1'b0;
      capture = sample && lat_rw && !lat_write;
`endif

      // Pins are registered from the next state so they change cleanly on the clock edge.
      rs_src     = load ? address[1] : lat_rs;
      rw_src     = load ? address[0] : lat_rw;
      active     = (next_state == ST_SETUP) || (next_state == ST_E_HIGH) || (next_state == ST_HOLD);
      next_e     = (next_state == ST_E_HIGH);
      next_rs    = active && !in_poll && rs_src;
      next_rw    = !active || in_poll || rw_src;
      next_drive = active && !in_poll && !rw_src;
      next_ack   = (next_state == ST_RECOVER) && (next_cnt == '0) && !in_poll;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ack       <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_RS    <= 1'b0;
         LCD_RW    <= 1'b1;
         drive     <= 1'b0;
         readdata  <= '0;
         lat_rs    <= 1'b0;
         lat_rw    <= 1'b1;
         lat_write <= 1'b0;
         lat_data  <= '0;
`ifdef LCD_BUSY_POLL_EN
         polling   <= 1'b0;
         busy      <= 1'b0;
         poll_cnt  <= '0;
`endif
      end else begin
         state  <= next_state;
         cnt    <= next_cnt;
         ack    <= next_ack;
         LCD_E  <= next_e;
         LCD_RS <= next_rs;
         LCD_RW <= next_rw;
         drive  <= next_drive;
         if (load) begin
            lat_rs    <= address[1];
            lat_rw    <= address[0];
            lat_write <= write;
            lat_data  <= writedata;
         end
         if (capture)
            readdata <= LCD_data;
`ifdef LCD_BUSY_POLL_EN
         polling <= next_polling;
         if (load)
            poll_cnt <= '0;
         else if (sample && polling) begin
            poll_cnt <= poll_cnt + 8'd1;
            busy     <= LCD_data[7];
         end
`endif
      end
   end

   assign waitrequest = (read || write) && !ack;
   assign LCD_data    = drive ? lat_data : 'z;

endmodule

// File: tb/tb_lcd_16207_timed_bridge.sv
// Self-checking bench for lcd_16207_timed_bridge: per-cycle pin/handshake checks against a phase-arithmetic model.
// Build with LCD_BUSY_POLL_EN defined to also exercise busy-flag polling.
module tb_lcd_16207_timed_bridge;
   localparam int S  = 2;
   localparam int EH = 23;
   localparam int H  = 1;
   localparam int R  = 24;
   localparam int PL = 255;
   localparam int T  = S + EH + H + R;

   logic       clk = 1'b0;
   logic       reset_n, read, write;
   logic [1:0] address;
   logic [7:0] writedata, readdata, lcd_val, rd_model;
   logic       waitrequest, LCD_E, LCD_RS, LCD_RW;
   wire  [7:0] lcd_bus;
   int         passes = 0, checks = 0, cyc = 0, last_rise = 0;

   lcd_16207_timed_bridge #(
      .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(H), .RECOVER_CYCLES(R), .POLL_LIMIT(PL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_data(lcd_bus)
   );

   // LCD model drives the bus only while it is being read with E high; pull-ups make an idle bus read 8'hFF.
   assign lcd_bus = (LCD_E && LCD_RW) ? lcd_val : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup pu (lcd_bus[i]);
   end

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1, "watchdog");
   end

   // One complete access; called at posedge+1, returns at posedge+1 of the first cycle after the ack.
   task automatic test_access(input string name, input logic rd, input logic wr, input logic [1:0] addr,
                              input logic [7:0] wd, input logic [7:0] lv, input int busy_polls);
      int p, total, j, l;
      logic poll_ph, act, e_x, rs_x, rw_x, drv, wr_x;
      logic [7:0] bus_x;
      p = 0;
`ifdef LCD_BUSY_POLL_EN
      if (wr || addr != 2'b01) p = (busy_polls >= PL) ? PL : busy_polls + 1;
`endif
      total = (p + 1) * T;
      read = rd; write = wr; address = addr; writedata = wd;
      for (int k = 0; k <= total; k++) begin
         j       = (k == 0) ? 0 : (k - 1) / T;
         l       = k - j * T;
         poll_ph = (j < p);
         lcd_val = poll_ph ? ((j < busy_polls) ? 8'h80 : 8'h04) : lv;
         @(negedge clk);
         act   = (k >= 1) && (l <= S + EH + H);
         e_x   = (l >= S + 1) && (l <= S + EH);
         rs_x  = act && !poll_ph && addr[1];
         rw_x  = !act || poll_ph || addr[0];
         drv   = act && !poll_ph && !addr[0];
         bus_x = drv ? wd : ((e_x && rw_x) ? lcd_val : 8'hFF);
         wr_x  = (k != total);
         if (!poll_ph && l == S + EH + 1 && !wr && addr[0]) rd_model = lv;
         checks++; if (LCD_E !== e_x) $display("FAIL %s E cycle %0d: got %b expected %b", name, k, LCD_E, e_x); else passes++;
         checks++; if (LCD_RS !== rs_x) $display("FAIL %s RS cycle %0d: got %b expected %b", name, k, LCD_RS, rs_x); else passes++;
         checks++; if (LCD_RW !== rw_x) $display("FAIL %s RW cycle %0d: got %b expected %b", name, k, LCD_RW, rw_x); else passes++;
         checks++; if (lcd_bus !== bus_x) $display("FAIL %s bus cycle %0d: got %h expected %h", name, k, lcd_bus, bus_x); else passes++;
         checks++; if (waitrequest !== wr_x) $display("FAIL %s waitrequest cycle %0d: got %b expected %b", name, k, waitrequest, wr_x); else passes++;
         checks++; if (readdata !== rd_model) $display("FAIL %s readdata cycle %0d: got %h expected %h", name, k, readdata, rd_model); else passes++;
         if (!poll_ph && l == S + 1) last_rise = cyc;
         @(posedge clk); #1;
      end
      read = 1'b0; write = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; read = 1'b1; write = 1'b0; address = 2'b00; writedata = 8'h00; lcd_val = 8'h00;
      rd_model = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (LCD_E !== 1'b0) $display("FAIL reset E: got %b expected 0", LCD_E); else passes++;
      checks++; if (LCD_RS !== 1'b0) $display("FAIL reset RS: got %b expected 0", LCD_RS); else passes++;
      checks++; if (LCD_RW !== 1'b1) $display("FAIL reset RW: got %b expected 1", LCD_RW); else passes++;
      checks++; if (readdata !== 8'h00) $display("FAIL reset readdata: got %h expected 00", readdata); else passes++;
      checks++; if (lcd_bus !== 8'hFF) $display("FAIL reset bus: got %h expected hi-Z(FF)", lcd_bus); else passes++;
      checks++; if (waitrequest !== 1'b1) $display("FAIL reset waitrequest w/ request: got %b expected 1", waitrequest); else passes++;
      read = 1'b0; #1;
      checks++; if (waitrequest !== 1'b0) $display("FAIL reset waitrequest idle: got %b expected 0", waitrequest); else passes++;
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      test_access("write41", 1'b0, 1'b1, 2'b10, 8'h41, 8'h00, 0);
   endtask

   task automatic test_read();
      test_access("read85", 1'b1, 1'b0, 2'b01, 8'h00, 8'h85, 0);
   endtask

   task automatic test_back_to_back();
      int r1, sep;
      test_access("b2b_01", 1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 0);
      r1 = last_rise;
      test_access("b2b_38", 1'b0, 1'b1, 2'b00, 8'h38, 8'h00, 0);
`ifdef LCD_BUSY_POLL_EN
      sep = 2 * T + 1;
`else
      sep = T + 1;
`endif
      checks++;
      if (last_rise - r1 !== sep) $display("FAIL b2b E rise spacing: got %0d expected %0d", last_rise - r1, sep);
      else passes++;
   endtask

   task automatic test_both();
      test_access("both0C", 1'b1, 1'b1, 2'b00, 8'h0C, 8'hA5, 0);
   endtask

   task automatic test_reset_mid();
      int target;
`ifdef LCD_BUSY_POLL_EN
      target = T + S + 10;
`else
      target = S + 10;
`endif
      lcd_val = 8'h04;
      read = 1'b0; write = 1'b1; address = 2'b10; writedata = 8'h55;
      repeat (target) begin @(posedge clk); #1; end
      checks++; if (LCD_E !== 1'b1) $display("FAIL rstmid E before reset: got %b expected 1", LCD_E); else passes++;
      reset_n = 1'b0;
      rd_model = 8'h00;
      @(posedge clk); #1;
      checks++; if (LCD_E !== 1'b0) $display("FAIL rstmid E: got %b expected 0", LCD_E); else passes++;
      checks++; if (LCD_RS !== 1'b0) $display("FAIL rstmid RS: got %b expected 0", LCD_RS); else passes++;
      checks++; if (LCD_RW !== 1'b1) $display("FAIL rstmid RW: got %b expected 1", LCD_RW); else passes++;
      checks++; if (lcd_bus !== 8'hFF) $display("FAIL rstmid bus: got %h expected hi-Z(FF)", lcd_bus); else passes++;
      checks++; if (readdata !== 8'h00) $display("FAIL rstmid readdata: got %h expected 00", readdata); else passes++;
      checks++; if (waitrequest !== 1'b1) $display("FAIL rstmid waitrequest: got %b expected 1", waitrequest); else passes++;
      @(posedge clk); #1 reset_n = 1'b1;
      test_access("rstmid_reissue", 1'b0, 1'b1, 2'b10, 8'h55, 8'h00, 0);
   endtask

   task automatic test_random();
      logic rd, wr;
      logic [1:0] addr;
      int busy;
      for (int n = 0; n < 12; n++) begin
         rd   = 1'($urandom_range(0, 1));
         wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         addr = 2'($urandom_range(0, 3));
`ifdef LCD_BUSY_POLL_EN
         busy = int'($urandom_range(0, 2));
`else
         busy = 0;
`endif
         test_access("random", rd, wr, addr, 8'($urandom_range(0, 254)), 8'($urandom), busy);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

`ifdef LCD_BUSY_POLL_EN
   task automatic test_poll();
      test_access("poll_busy3", 1'b0, 1'b1, 2'b10, 8'h41, 8'h00, 3);
      test_access("poll_status_read", 1'b1, 1'b0, 2'b01, 8'h00, 8'h9A, 5);
      test_access("poll_stuck", 1'b0, 1'b1, 2'b10, 8'h42, 8'h00, 1000);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_both();
      test_reset_mid();
      test_random();
`ifdef LCD_BUSY_POLL_EN
      test_poll();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
